// File: rtl/rf_writeback.sv
// Register-file write-back: merges ALU results and queued load data into one registered
// RF write per cycle, with a pending-load scoreboard. Define RF_WB_BYPASS_EN for bypass ports.
module rf_writeback #(
  parameter int LQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_stall,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  input  logic        issue_mark,
  input  logic [4:0]  issue_rd,
  output logic [31:0] pend,
  output logic [4:0]  reg_addr_write,
  output logic [31:0] reg_data_write,
  output logic        reg_enable_write,
`ifdef RF_WB_BYPASS_EN
  input  logic [4:0]  byp_rs1,
  input  logic [4:0]  byp_rs2,
  output logic        byp_hit1,
  output logic        byp_hit2,
  output logic [31:0] byp_data1,
  output logic [31:0] byp_data2,
`endif
  output logic        wb_err
);

  localparam int PW = $clog2(LQ_DEPTH);
  localparam int CW = $clog2(LQ_DEPTH) + 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] CNT_FULL = CW'(LQ_DEPTH);

  logic [4:0]    r_q_rd   [LQ_DEPTH];
  logic [31:0]   r_q_data [LQ_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_pend;
  logic          r_err;
  logic          r_we;
  logic [4:0]    r_addr;
  logic [31:0]   r_data;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [4:0]    w_head_rd;
  logic [31:0]   w_head_data;
  logic [31:0]   w_pend_clr;
  logic [31:0]   w_pend_set;
  logic [31:0]   w_pend_next;
  logic          w_err_set;

  // Queue status, arbitration, scoreboard next-state and protocol checks
  always_comb begin
    w_full      = (r_count == CNT_FULL);
    w_empty     = (r_count == {CW{1'b0}});
    w_push      = ld_valid && !w_full;
    w_pop       = !alu_valid && !w_empty;
    w_head_rd   = r_q_rd[r_rptr];
    w_head_data = r_q_data[r_rptr];
    w_pend_clr  = 32'h0000_0000;
    w_pend_set  = 32'h0000_0000;
    if (w_pop) begin
      w_pend_clr[w_head_rd] = 1'b1;
    end else begin
      w_pend_clr = 32'h0000_0000;
    end
    if (issue_mark && (issue_rd != 5'd0)) begin
      w_pend_set[issue_rd] = 1'b1;
    end else begin
      w_pend_set = 32'h0000_0000;
    end
    // Set is applied after clear so a same-cycle re-issue keeps the bit; x0 never pends.
    w_pend_next = ((r_pend & ~w_pend_clr) | w_pend_set) & 32'hFFFF_FFFE;
    w_err_set   = (alu_valid && w_full)
                || (alu_valid && (alu_rd != 5'd0) && r_pend[alu_rd])
                || (w_pop && (w_head_rd != 5'd0) && !r_pend[w_head_rd]);
  end

  assign ld_ready         = !w_full;
  assign alu_stall        = w_full;
  assign pend             = r_pend;
  assign wb_err           = r_err;
  assign reg_enable_write = r_we;
  assign reg_addr_write   = r_addr;
  assign reg_data_write   = r_data;

  // Load queue storage; contents are don't-care until the count covers them
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_rd[r_wptr]   <= ld_rd;
      r_q_data[r_wptr] <= ld_data;
    end
  end

  // Queue pointers/count, scoreboard, error flag and the registered write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= {PW{1'b0}};
      r_rptr  <= {PW{1'b0}};
      r_count <= {CW{1'b0}};
      r_pend  <= 32'h0000_0000;
      r_err   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= 5'd0;
      r_data  <= 32'h0000_0000;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      r_pend <= w_pend_next;
      if (w_err_set) begin
        r_err <= 1'b1;
      end
      if (alu_valid) begin
        r_we   <= (alu_rd != 5'd0);
        r_addr <= alu_rd;
        r_data <= alu_data;
      end else if (w_pop) begin
        r_we   <= (w_head_rd != 5'd0);
        r_addr <= w_head_rd;
        r_data <= w_head_data;
      end else begin
        r_we   <= 1'b0;
      end
    end
  end

`ifdef RF_WB_BYPASS_EN
  // Forward the in-flight RF write to readers in the same cycle
  always_comb begin
    byp_hit1  = r_we && (byp_rs1 != 5'd0) && (r_addr == byp_rs1);
    byp_hit2  = r_we && (byp_rs2 != 5'd0) && (r_addr == byp_rs2);
    byp_data1 = r_data;
    byp_data2 = r_data;
  end
`endif

endmodule

// File: tb/tb_rf_writeback.sv
// Self-checking bench for rf_writeback: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_rf_writeback;
  localparam int LQ_DEPTH = 2;

  logic        clk;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_stall;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        issue_mark;
  logic [4:0]  issue_rd;
  logic [31:0] pend;
  logic [4:0]  reg_addr_write;
  logic [31:0] reg_data_write;
  logic        reg_enable_write;
  logic        wb_err;
`ifdef RF_WB_BYPASS_EN
  logic [4:0]  byp_rs1;
  logic [4:0]  byp_rs2;
  logic        byp_hit1;
  logic        byp_hit2;
  logic [31:0] byp_data1;
  logic [31:0] byp_data2;
`endif

  int n_checks;
  int n_errors;

  logic [4:0]  q_rd[$];
  logic [31:0] q_data[$];
  logic [31:0] m_pend;
  logic        m_err;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [4:0]  outst[$];
  bit          r_full;

  rf_writeback #(.LQ_DEPTH(LQ_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .issue_mark(issue_mark), .issue_rd(issue_rd), .pend(pend),
    .reg_addr_write(reg_addr_write), .reg_data_write(reg_data_write),
    .reg_enable_write(reg_enable_write),
`ifdef RF_WB_BYPASS_EN
    .byp_rs1(byp_rs1), .byp_rs2(byp_rs2), .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
    .byp_data1(byp_data1), .byp_data2(byp_data2),
`endif
    .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q_rd.delete();
    q_data.delete();
    outst.delete();
    m_pend = 32'h0;
    m_err  = 1'b0;
    m_we   = 1'b0;
    m_addr = 5'd0;
    m_data = 32'h0;
  endtask

  // One cycle of the write-back rules applied to the current inputs.
  task automatic model_step();
    bit full;
    logic [4:0] hrd;
    full = (q_rd.size() == LQ_DEPTH);
    if (alu_valid && full) m_err = 1'b1;
    if (alu_valid && alu_rd != 5'd0 && m_pend[alu_rd]) m_err = 1'b1;
    if (alu_valid) begin
      m_we = (alu_rd != 5'd0); m_addr = alu_rd; m_data = alu_data;
    end else if (q_rd.size() > 0) begin
      hrd = q_rd.pop_front();
      m_data = q_data.pop_front();
      m_addr = hrd;
      m_we = (hrd != 5'd0);
      if (hrd != 5'd0 && !m_pend[hrd]) m_err = 1'b1;
      m_pend[hrd] = 1'b0;
    end else begin
      m_we = 1'b0;
    end
    if (ld_valid && !full) begin
      q_rd.push_back(ld_rd);
      q_data.push_back(ld_data);
    end
    if (issue_mark && issue_rd != 5'd0) m_pend[issue_rd] = 1'b1;
    m_pend[0] = 1'b0;
  endtask

  task automatic chk_regs(input string pfx);
    chk({pfx, "_we"},   32'(reg_enable_write), 32'(m_we));
    chk({pfx, "_addr"}, 32'(reg_addr_write),   32'(m_addr));
    chk({pfx, "_data"}, reg_data_write,        m_data);
    chk({pfx, "_pend"}, pend,                  m_pend);
    chk({pfx, "_err"},  32'(wb_err),           32'(m_err));
  endtask

  // Inputs are applied at the falling edge; combinational outputs checked there, registers after the edge.
  task automatic step();
    chk("ld_ready",  32'(ld_ready),  32'(q_rd.size() != LQ_DEPTH));
    chk("alu_stall", 32'(alu_stall), 32'(q_rd.size() == LQ_DEPTH));
    model_step();
    @(posedge clk);
    #1;
    chk_regs("cyc");
    @(negedge clk);
  endtask

  task automatic idle();
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'h0;
    ld_valid = 1'b0; ld_rd = 5'd0; ld_data = 32'h0;
    issue_mark = 1'b0; issue_rd = 5'd0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    clk = 1'b0;
    rst_n = 1'b1;
    idle();
`ifdef RF_WB_BYPASS_EN
    byp_rs1 = 5'd0;
    byp_rs2 = 5'd0;
`endif
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    chk_regs("rst");
    chk("rst_ld_ready",  32'(ld_ready),  32'd1);
    chk("rst_alu_stall", 32'(alu_stall), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // ALU write, one-cycle latency
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
    step();
    chk("t1_we",   32'(reg_enable_write), 32'd1);
    chk("t1_addr", 32'(reg_addr_write),   32'd5);
    chk("t1_data", reg_data_write,        32'hDEAD_BEEF);
    chk("t1_pend", pend,                  32'h0);

    alu_rd = 5'd4; alu_data = 32'h0000_0055;
    step();
`ifdef RF_WB_BYPASS_EN
    byp_rs1 = 5'd4;
    byp_rs2 = 5'd0;
    #1;
    chk("byp_hit1",  32'(byp_hit1), 32'd1);
    chk("byp_data1", byp_data1,     32'h0000_0055);
    chk("byp_hit2",  32'(byp_hit2), 32'd0);
`endif

    // Scoreboard set and clear with the load write
    idle();
    issue_mark = 1'b1; issue_rd = 5'd7;
    step();
    idle();
    repeat (3) step();
    chk("t2_pend7_held", 32'(pend[7]), 32'd1);
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h11;
    step();
    chk("t2_pend7_acc", 32'(pend[7]), 32'd1);
    chk("t2_no_we",     32'(reg_enable_write), 32'd0);
    idle();
    step();
    chk("t2_we",        32'(reg_enable_write), 32'd1);
    chk("t2_data",      reg_data_write,        32'h11);
    chk("t2_pend7_clr", 32'(pend[7]),          32'd0);

    // Fill the queue behind ALU traffic, then drain
    issue_mark = 1'b1; issue_rd = 5'd1; step();
    issue_rd = 5'd2; step();
    idle();
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hA0A0_A0A0;
    ld_valid = 1'b1; ld_rd = 5'd1; ld_data = 32'h101;
    step();
    alu_rd = 5'd11; alu_data = 32'hB0B0_B0B0;
    ld_rd = 5'd2; ld_data = 32'h202;
    step();
    chk("t3_full_ready", 32'(ld_ready),  32'd0);
    chk("t3_full_stall", 32'(alu_stall), 32'd1);
    idle();
    step();
    chk("t3_rd1", 32'(reg_addr_write), 32'd1);
    step();
    chk("t3_rd2",   32'(reg_addr_write), 32'd2);
    chk("t3_ready", 32'(ld_ready),       32'd1);

    // Re-issue on the committing cycle keeps pend; x0 load pops without a strobe
    issue_mark = 1'b1; issue_rd = 5'd9; step();
    idle();
    ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h99; step();
    idle();
    issue_mark = 1'b1; issue_rd = 5'd9; step();
    chk("t4_pend9_kept", 32'(pend[9]), 32'd1);
    idle();
    ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h1234; step();
    idle();
    step();
    chk("t4_x0_no_we", 32'(reg_enable_write), 32'd0);
    ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h999; step();
    idle();
    step();
    chk("t4_pend_empty", pend, 32'h0);

    // Randomized legal traffic
    for (int c = 0; c < 400; c++) begin
      r_full = (q_rd.size() == LQ_DEPTH);
      alu_rd = 5'($urandom_range(31, 0));
      alu_data = $urandom;
      alu_valid = ($urandom_range(2, 0) == 0) && !r_full && !m_pend[alu_rd];
      issue_rd = 5'($urandom_range(31, 1));
      issue_mark = ($urandom_range(3, 0) == 0) && !m_pend[issue_rd];
      ld_data = $urandom;
      if (outst.size() > 0) begin
        ld_valid = ($urandom_range(1, 0) == 0);
        ld_rd = outst[0];
      end else begin
        ld_valid = ($urandom_range(7, 0) == 0);
        ld_rd = 5'd0;
      end
      if (ld_valid && !r_full && ld_rd != 5'd0) void'(outst.pop_front());
      if (issue_mark) outst.push_back(issue_rd);
      step();
    end
    idle();
    chk("rand_no_err", 32'(wb_err), 32'd0);
    repeat (4) step();

    // Sticky error, then reset in the middle of a drain
    issue_mark = 1'b1; issue_rd = 5'd3; step();
    idle();
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33; step();
    chk("t5_err", 32'(wb_err), 32'd1);
    idle();
    issue_mark = 1'b1; issue_rd = 5'd20; step();
    issue_rd = 5'd21; step();
    idle();
    alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'hC;
    ld_valid = 1'b1; ld_rd = 5'd20; ld_data = 32'h2020; step();
    ld_rd = 5'd21; ld_data = 32'h2121; step();
    idle();
    step();
    chk("t5_err_held", 32'(wb_err),           32'd1);
    chk("t5_drain_we", 32'(reg_enable_write), 32'd1);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_regs("t5_rst");
    chk("t5_rst_ready", 32'(ld_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("t5_empty_no_we", 32'(reg_enable_write), 32'd0);
    chk("t5_empty_ready", 32'(ld_ready),         32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rf_writeback.md
# rf_writeback

Write-back unit that owns the register file write port (`reg_addr_write`, `reg_data_write`, `reg_enable_write`) in the multi-cycle core. It merges two result sources into one registered write per cycle: single-cycle ALU results and out-of-order-timed load data from the memory unit. It also keeps a pending-load scoreboard so decode can stall on RAW hazards against outstanding loads.

## Interface

Parameters:

- `LQ_DEPTH`, 2: load skid queue entries (power of two, ≥2).

Ports:

- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `alu_valid` in 1: ALU result present this cycle.
- `alu_rd` in 5: ALU destination register.
- `alu_data` in 32: ALU result.
- `alu_stall` out 1: combinational; high when the load queue is full. Pipeline must hold off ALU results while it is high.
- `ld_valid` in 1: load data offered.
- `ld_ready` out 1: queue not full; transfer when `ld_valid && ld_ready`.
- `ld_rd` in 5: load destination.
- `ld_data` in 32: load data.
- `issue_mark` in 1: a load is being issued this cycle.
- `issue_rd` in 5: destination of the issued load.
- `pend` out 32: scoreboard, bit n = load to xn outstanding.
- `reg_addr_write` out 5: RF write address.
- `reg_data_write` out 32: RF write data.
- `reg_enable_write` out 1: RF write strobe.
- `wb_err` out 1: sticky protocol-violation flag.

## Operation

- Load queue:
  - FIFO of {rd, data}, `LQ_DEPTH` entries, with wrapping read/write pointers and a count of width clog2(`LQ_DEPTH`)+1.
  - `ld_ready = (count != LQ_DEPTH)`.
- Arbitration, each cycle:
  - If `alu_valid`, the ALU result is written.
  - Otherwise, if the queue is non-empty, the head is popped and written.
  - Otherwise nothing is written.
- Push and pop in the same cycle: count is unchanged. A push into a full queue cannot occur because `ld_ready` is low.
- Writes to x0:
  - From either source, the write is consumed but `reg_enable_write` stays 0.
  - A load to x0 still pops from the queue.
- Scoreboard:
  - `issue_mark` with `issue_rd != 0` sets `pend[issue_rd]`.
  - A load write committed to rd clears `pend[rd]`.
  - If set and clear target the same rd in the same cycle, set wins.
  - `pend[0]` is always 0.
- `wb_err` is set and held until reset by any of:
  - `alu_valid` while `alu_stall` is high.
  - `alu_valid` with `alu_rd` nonzero and `pend[alu_rd]` set.
  - A load committing to rd with `pend[rd]` clear.
- Reset mid-operation: the queue is discarded, the scoreboard is cleared, and the write strobe drops immediately because reset is asynchronous.

## Timing

- Reset values:
  - `reg_enable_write` = 0, `reg_addr_write` = 0, `reg_data_write` = 0.
  - `pend` = 0, `wb_err` = 0, queue empty.
  - `ld_ready` = 1, `alu_stall` = 0.
- Latency:
  - ALU result to RF write: 1 cycle. The write outputs are registered, so the RF captures the value on the following edge.
  - Load accepted into an empty queue with no ALU traffic: written 1 cycle after acceptance.
  - Each ALU cycle delays queued loads by one cycle.
- `pend` clears on the same edge that asserts `reg_enable_write` for that load. It is registered; there is no combinational path from `ld_*` to `pend`.
- Throughput: one RF write per cycle.

## Configuration

- `RF_WB_BYPASS_EN` defined adds these ports:
  - Inputs: `byp_rs1` (5), `byp_rs2` (5).
  - Outputs: `byp_hit1`/`byp_hit2` (1), `byp_data1`/`byp_data2` (32).
- Bypass behaviour:
  - A hit is asserted combinationally when `reg_enable_write` is high and `reg_addr_write` equals the rs; the data is `reg_data_write`.
  - This covers the RF read-during-write cycle.
  - rs = 0 never hits.
- Not defined: the ports are absent and behaviour is otherwise identical.

## Test plan

- Reset release, then `alu_valid`, rd=5, data=0xDEADBEEF → next cycle `reg_enable_write`=1, addr=5, data=0xDEADBEEF; all other state unchanged.
- `issue_mark` rd=7; 3 cycles later load rd=7, data=0x11 with no ALU traffic → `pend[7]`=1 until the write cycle, then 0 with the write.
- Fill the queue with loads to rd 1 and 2 while the ALU writes every cycle → `ld_ready`=0 and `alu_stall`=1. Drop `alu_valid` → rd1 then rd2 written on consecutive cycles, and `ld_ready` returns to 1.
- `issue_mark` rd=9 in the same cycle a load to rd=9 commits → `pend[9]` stays 1. A load to x0 → no write strobe, queue count decrements.
- ALU write to rd=3 while `pend[3]`=1 → `wb_err`=1, held until `rst_n` is pulsed low. Assert `rst_n` low mid-drain → outputs reset immediately and the queue is empty after release.
- With `RF_WB_BYPASS_EN`: during a write of 0x55 to x4, `byp_rs1`=4 → `byp_hit1`=1, `byp_data1`=0x55; `byp_rs2`=0 → `byp_hit2`=0.
